// File: rtl/piso_rr_serializer.sv
// Round-robin shared PISO serializer: framed LSB-first words with an idle gap.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_rr_serializer #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*WIDTH-1:0]    req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     ser_out,
    output logic                     ser_valid,
    output logic                     frame_start,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy
);

    localparam int IDW = $clog2(NREQ);
`ifdef PISO_PARITY_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif
    localparam int CW = $clog2(FLEN + 1);
    localparam int GW = $clog2(GAP + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_PAR,
        S_GAP
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   grant_q, grant_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             fstart_q, fstart_d;
`ifdef PISO_PARITY_EN
    logic             par_q, par_d;
`endif

    logic             last_bit;
    logic             frame_end;
    logic             win_open;
    logic             win_found;
    logic             accept;
    logic [IDW-1:0]   win_id;
    logic [IDW-1:0]   cand;
    logic [WIDTH-1:0] win_word;

    assign last_bit = (state_q == S_SHIFT) && (cnt_q == CW'(WIDTH));
`ifdef PISO_PARITY_EN
    assign frame_end = (state_q == S_PAR);
`else
    assign frame_end = last_bit;
`endif

    // Back-to-back frames need the grant in the frame's final cycle.
    assign win_open = !reset &&
                      ((state_q == S_IDLE) || ((GAP == 0) && frame_end));

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int i = NREQ; i >= 1; i--) begin
            cand = IDW'((int'(ptr_q) + i) % NREQ);
            if (req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign win_word = req_data[int'(win_id)*WIDTH +: WIDTH];
    assign accept   = win_open && win_found;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[win_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            gap_q       <= '0;
            shreg_q     <= '0;
            ptr_q       <= IDW'(NREQ - 1);
            grant_q     <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            fstart_q    <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            shreg_q     <= shreg_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            fstart_q    <= fstart_d;
`ifdef PISO_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        shreg_d = shreg_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
`ifdef PISO_PARITY_EN
        par_d   = par_q;
`endif
        if (accept) begin
            // Bit 0 leaves on the accept edge, so keep only the rest.
            state_d = S_SHIFT;
            cnt_d   = CW'(1);
            gap_d   = '0;
            shreg_d = win_word >> 1;
            ptr_d   = win_id;
            grant_d = win_id;
`ifdef PISO_PARITY_EN
            par_d   = ^win_word;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_SHIFT: begin
                    if (!last_bit) begin
                        cnt_d   = cnt_q + CW'(1);
                        shreg_d = shreg_q >> 1;
                    end else begin
`ifdef PISO_PARITY_EN
                        state_d = S_PAR;
                        cnt_d   = cnt_q + CW'(1);
`else
                        cnt_d = '0;
                        if (GAP == 0) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_GAP;
                            gap_d   = GW'(1);
                        end
`endif
                    end
                end
                S_PAR: begin
                    cnt_d = '0;
                    if (GAP == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_GAP;
                        gap_d   = GW'(1);
                    end
                end
                S_GAP: begin
                    if (gap_q == GW'(GAP)) begin
                        state_d = S_IDLE;
                        gap_d   = '0;
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        ser_valid_d = 1'b0;
        ser_out_d   = 1'b0;
        fstart_d    = 1'b0;
        if (accept) begin
            ser_valid_d = 1'b1;
            ser_out_d   = win_word[0];
            fstart_d    = 1'b1;
        end else if (state_q == S_SHIFT) begin
            if (!last_bit) begin
                ser_valid_d = 1'b1;
                ser_out_d   = shreg_q[0];
            end
`ifdef PISO_PARITY_EN
            else begin
                ser_valid_d = 1'b1;
                ser_out_d   = par_q;
            end
`endif
        end
    end

    assign ser_out     = ser_out_q;
    assign ser_valid   = ser_valid_q;
    assign frame_start = fstart_q;
    assign grant_id    = grant_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_piso_rr_serializer.sv
// Directed bench for piso_rr_serializer: one GAP=1 and one GAP=0 instance.
// Frame checks include the parity bit when PISO_PARITY_EN is defined.
module tb_piso_rr_serializer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0][3:0]  rv;
    logic [1:0][15:0] rd;
    logic [1:0][3:0]  rr;
    logic [1:0]       so, sv, fs, bs;
    logic [1:0][1:0]  gid;

    int n_chk = 0;
    int n_err = 0;

    piso_rr_serializer #(.NREQ(4), .WIDTH(4), .GAP(1)) u_gap1 (
        .clk(clk), .reset(reset),
        .req_valid(rv[0]), .req_data(rd[0]), .req_ready(rr[0]),
        .ser_out(so[0]), .ser_valid(sv[0]), .frame_start(fs[0]),
        .grant_id(gid[0]), .busy(bs[0])
    );

    piso_rr_serializer #(.NREQ(4), .WIDTH(4), .GAP(0)) u_gap0 (
        .clk(clk), .reset(reset),
        .req_valid(rv[1]), .req_data(rd[1]), .req_ready(rr[1]),
        .ser_out(so[1]), .ser_valid(sv[1]), .frame_start(fs[1]),
        .grant_id(gid[1]), .busy(bs[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in the first bit cycle; returns in the cycle after the frame.
    task automatic frame(input int g, input logic [1:0] id,
                         input logic [3:0] w, input logic [3:0] lr);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("frm_valid", 32'(sv[g]), 1);
            chk("frm_bit",   32'(so[g]), 32'(w[k]));
            chk("frm_start", 32'(fs[g]), 32'(k == 0));
            chk("frm_gid",   32'(gid[g]), 32'(id));
            chk("frm_busy",  32'(bs[g]), 1);
`ifdef PISO_PARITY_EN
            chk("frm_ready", 32'(rr[g]), 0);
`else
            chk("frm_ready", 32'(rr[g]), (k == 3) ? 32'(lr) : 0);
`endif
            tick();
        end
`ifdef PISO_PARITY_EN
        #1;
        chk("par_valid", 32'(sv[g]), 1);
        chk("par_bit",   32'(so[g]), 32'(^w));
        chk("par_start", 32'(fs[g]), 0);
        chk("par_ready", 32'(rr[g]), 32'(lr));
        tick();
`endif
    endtask

    logic [3:0] w2 [4];
    logic [1:0] id;

    initial begin
        rv = '0;
        rd = '0;
        w2[0] = 4'b0011;
        w2[1] = 4'b0101;
        w2[2] = 4'b1001;
        w2[3] = 4'b0111;

        // Reset values, with a request pending to prove ready is gated
        reset = 1'b1;
        rv[0] = 4'b0001;
        tick();
        tick();
        chk("rst_valid", 32'(sv[0]), 0);
        chk("rst_out",   32'(so[0]), 0);
        chk("rst_start", 32'(fs[0]), 0);
        chk("rst_busy",  32'(bs[0]), 0);
        chk("rst_gid",   32'(gid[0]), 0);
        chk("rst_ready", 32'(rr[0]), 0);

        // Single requester 0, word 0110
        reset = 1'b0;
        rd[0][3:0] = 4'b0110;
        #1;
        chk("t1_ready", 32'(rr[0]), 32'h1);
        tick();
        rv[0] = '0;
        frame(0, 2'd0, 4'b0110, 4'b0000);
        #1;
        chk("t1_gap_valid", 32'(sv[0]), 0);
        chk("t1_gap_busy",  32'(bs[0]), 1);
        tick();
        chk("t1_idle_busy", 32'(bs[0]), 0);

        // All four requesters held: grants 0,1,2,3,0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd[0] = {w2[3], w2[2], w2[1], w2[0]};
        rv[0] = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            id = 2'(n % 4);
            #1;
            chk("t2_ready", 32'(rr[0]), 32'(4'b0001 << id));
            chk("t2_idle",  32'(bs[0]), 0);
            tick();
            frame(0, id, w2[id], 4'b0000);
            #1;
            chk("t2_gap_valid", 32'(sv[0]), 0);
            chk("t2_gap_ready", 32'(rr[0]), 0);
            chk("t2_gap_busy",  32'(bs[0]), 1);
            tick();
        end
        rv[0] = '0;

        // GAP=0: two frames back to back
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd[1][7:0] = {4'b1011, 4'b0110};
        rv[1] = 4'b0011;
        #1;
        chk("t3_ready", 32'(rr[1]), 32'h1);
        tick();
        frame(1, 2'd0, 4'b0110, 4'b0010);
        rv[1] = '0;
        frame(1, 2'd1, 4'b1011, 4'b0000);
        #1;
        chk("t3_end_valid", 32'(sv[1]), 0);
        chk("t3_end_busy",  32'(bs[1]), 0);
        tick();

        // Reset during the second bit of a frame
        rd[0][3:0] = 4'b1010;
        rv[0] = 4'b0001;
        #1;
        chk("t4_ready", 32'(rr[0]), 32'h1);
        tick();
        #1;
        chk("t4_bit0",   32'(so[0]), 0);
        chk("t4_start",  32'(fs[0]), 1);
        tick();
        #1;
        chk("t4_bit1",   32'(so[0]), 1);
        reset = 1'b1;
        tick();
        chk("t4_valid",  32'(sv[0]), 0);
        chk("t4_busy",   32'(bs[0]), 0);
        chk("t4_gid",    32'(gid[0]), 0);
        chk("t4_out",    32'(so[0]), 0);
        chk("t4_rready", 32'(rr[0]), 0);
        reset = 1'b0;
        rv[0] = 4'b1000;
        rd[0][15:12] = 4'b0101;
        #1;
        chk("t4_req3", 32'(rr[0]), 32'h8);
        tick();
        frame(0, 2'd3, 4'b0101, 4'b0000);
        rv[0] = '0;
        #1;
        chk("t4_gap_valid", 32'(sv[0]), 0);
        tick();

        // Requests pulsed mid-frame are ignored
        rd[0][11:8] = 4'b1100;
        rv[0] = 4'b0100;
        #1;
        chk("t6_ready", 32'(rr[0]), 32'h4);
        tick();
        rv[0] = 4'b1011;
        frame(0, 2'd2, 4'b1100, 4'b0000);
        rv[0] = '0;
        #1;
        chk("t6_gap_valid", 32'(sv[0]), 0);
        tick();
        chk("t6_idle_busy",  32'(bs[0]), 0);
        chk("t6_idle_ready", 32'(rr[0]), 0);
        chk("t6_idle_valid", 32'(sv[0]), 0);
        tick();
        chk("t6_no_dup_valid", 32'(sv[0]), 0);
        chk("t6_no_dup_busy",  32'(bs[0]), 0);
        chk("t6_gid",          32'(gid[0]), 2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
